// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch FIFO between fetch (PC/imem) and the IF/ID register.
//
// Queues fetched {instr, pc} pairs while decode is stalled and presents them in order.
// A flush (taken branch/jump) empties the queue in one cycle. When empty the head outputs
// present a NOP bubble with PC 0 so IF/ID always latches a legal instruction.
//
// Parameters:
//   WIDTH  instruction and PC width in bits
//   DEPTH  number of entries (power of two, >= 2)
//   NOP    instruction presented while empty
//
// Ports:
//   CLK       clock, rising edge
//   Reset     asynchronous active-low reset
//   Flush     synchronous clear of all entries, overrides push/pop
//   InValid   upstream holds a valid fetched instruction
//   InInstr   fetched instruction
//   InPC      PC of fetched instruction
//   InReady   buffer accepts a push this cycle (registered state only)
//   OutEN     IF/ID enable; consumes the head entry when OutValid
//   OutValid  head entry is valid
//   OutInstr  head instruction, or NOP when empty
//   OutPC     head PC, or 0 when empty
//   Count     number of occupied entries

module fetch_buffer #(
    parameter int unsigned       WIDTH = 32,
    parameter int unsigned       DEPTH = 4,
    parameter logic [WIDTH-1:0]  NOP   = 32'h00000013
) (
    input  logic                     CLK,
    input  logic                     Reset,
    input  logic                     Flush,
    input  logic                     InValid,
    input  logic [WIDTH-1:0]         InInstr,
    input  logic [WIDTH-1:0]         InPC,
    output logic                     InReady,
    input  logic                     OutEN,
    output logic                     OutValid,
    output logic [WIDTH-1:0]         OutInstr,
    output logic [WIDTH-1:0]         OutPC,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

    // Entry layout: {instr, pc}
    logic [2*WIDTH-1:0] mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q,  count_d;

    logic push;
    logic pop;
    logic not_full;
    logic not_empty;

    // Ready/valid come from registered occupancy only: no push-through when full and
    // no bypass when empty, which keeps InReady free of any path from OutEN.
    assign not_full  = (count_q != CntFull);
    assign not_empty = (count_q != '0);

    assign push = InValid & not_full & ~Flush;
    assign pop  = not_empty & OutEN & ~Flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the mod-DEPTH wrap.
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are never visible while count is zero.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {InInstr, InPC};
        end
    end

    always_comb begin
        InReady  = not_full;
        OutValid = not_empty;
        Count    = count_q;
        OutInstr = NOP;
        OutPC    = '0;
        if (not_empty) begin
            OutInstr = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
            OutPC    = mem_q[rd_ptr_q][WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        Flush = 1'b0;
    logic        InValid = 1'b0;
    logic [31:0] InInstr = '0;
    logic [31:0] InPC = '0;
    logic        InReady;
    logic        OutEN = 1'b0;
    logic        OutValid;
    logic [31:0] OutInstr;
    logic [31:0] OutPC;
    logic [2:0]  Count;

    int checks = 0;
    int failures = 0;

    // Scoreboard of expected {instr, pc} in push order.
    logic [63:0] sb[$];

    fetch_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NOP   (NOP)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Flush    (Flush),
        .InValid  (InValid),
        .InInstr  (InInstr),
        .InPC     (InPC),
        .InReady  (InReady),
        .OutEN    (OutEN),
        .OutValid (OutValid),
        .OutInstr (OutInstr),
        .OutPC    (OutPC),
        .Count    (Count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hB000_0000 | (pc << 4) | 32'h3;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc);
        InValid = v;
        InPC    = pc;
        InInstr = instr_of(pc);
    endtask

    // Record what the buffer must accept at the coming edge (occupancy before the edge).
    task automatic model_push();
        if (InValid && !Flush && sb.size() < DEPTH) sb.push_back({InInstr, InPC});
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        tick();
        tick();
        checks++;
        if (OutInstr !== NOP) begin
            failures++;
            $display("FAIL reset_instr: got %h expected %h", OutInstr, NOP);
        end
        checks++;
        if (OutPC !== 32'h0) begin
            failures++;
            $display("FAIL reset_pc: got %h expected 0", OutPC);
        end
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || Count !== 3'd0) begin
            failures++;
            $display("FAIL reset_flags: got ready=%b valid=%b count=%0d expected 1 0 0",
                     InReady, OutValid, Count);
        end
        Reset = 1'b1;
        sb.delete();
    endtask

    task automatic test_fill(input logic [31:0] base);
        OutEN = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_in(1'b1, base + 32'(4 * i));
            model_push();
            tick();
        end
        checks++;
        if (Count !== 3'd4 || InReady !== 1'b0 || OutValid !== 1'b1) begin
            failures++;
            $display("FAIL fill_full: got count=%0d ready=%b valid=%b expected 4 0 1",
                     Count, InReady, OutValid);
        end
        checks++;
        if (OutPC !== base) begin
            failures++;
            $display("FAIL fill_head: got pc=%h expected %h", OutPC, base);
        end
        set_in(1'b0, '0);
    endtask

    task automatic test_overfill();
        set_in(1'b1, 32'h10);
        model_push();
        tick();
        set_in(1'b0, '0);
        checks++;
        if (Count !== 3'd4 || OutPC !== 32'h0) begin
            failures++;
            $display("FAIL overfill: got count=%0d pc=%h expected 4 00000000", Count, OutPC);
        end
    endtask

    task automatic test_drain(input int n);
        logic [63:0] exp;
        OutEN = 1'b1;
        for (int i = 0; i < n; i++) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 64'h0;
            checks++;
            if (OutValid !== 1'b1 || {OutInstr, OutPC} !== exp) begin
                failures++;
                $display("FAIL drain_%0d: got valid=%b instr=%h pc=%h expected 1 %h %h",
                         i, OutValid, OutInstr, OutPC, exp[63:32], exp[31:0]);
            end
            tick();
        end
        OutEN = 1'b0;
    endtask

    task automatic test_empty();
        checks++;
        if (OutValid !== 1'b0 || OutInstr !== NOP || OutPC !== 32'h0 || Count !== 3'd0) begin
            failures++;
            $display("FAIL empty: got valid=%b instr=%h pc=%h count=%0d expected 0 %h 0 0",
                     OutValid, OutInstr, OutPC, Count, NOP);
        end
        OutEN = 1'b1;
        tick();
        OutEN = 1'b0;
        checks++;
        if (Count !== 3'd0 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL empty_pop: got count=%0d ready=%b expected 0 1", Count, InReady);
        end
    endtask

    task automatic test_stream();
        logic [63:0] exp;
        int popped = 0;
        OutEN = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            set_in(c < 12, 32'h100 + 32'(4 * c));
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                popped++;
                checks++;
                if (OutValid !== 1'b1 || {OutInstr, OutPC} !== exp) begin
                    failures++;
                    $display("FAIL stream_%0d: got valid=%b instr=%h pc=%h expected 1 %h %h",
                             c, OutValid, OutInstr, OutPC, exp[63:32], exp[31:0]);
                end
            end
            model_push();
            tick();
            if (c < 12) begin
                checks++;
                if (Count !== 3'd1) begin
                    failures++;
                    $display("FAIL stream_count_%0d: got %0d expected 1", c, Count);
                end
            end
        end
        set_in(1'b0, '0);
        OutEN = 1'b0;
        checks++;
        if (popped != 12 || Count !== 3'd0) begin
            failures++;
            $display("FAIL stream_total: got popped=%0d count=%0d expected 12 0", popped, Count);
        end
    endtask

    task automatic test_full_pop();
        logic [63:0] exp;
        test_fill(32'h200);
        set_in(1'b1, 32'h210);
        OutEN = 1'b1;
        exp = sb.pop_front();
        checks++;
        if ({OutInstr, OutPC} !== exp) begin
            failures++;
            $display("FAIL fullpop_head: got pc=%h expected %h", OutPC, exp[31:0]);
        end
        model_push();
        tick();
        OutEN = 1'b0;
        checks++;
        if (Count !== 3'd3 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL fullpop_only_pop: got count=%0d ready=%b expected 3 1", Count, InReady);
        end
        model_push();
        tick();
        set_in(1'b0, '0);
        checks++;
        if (Count !== 3'd4) begin
            failures++;
            $display("FAIL fullpop_held_push: got count=%0d expected 4", Count);
        end
        test_drain(4);
    endtask

    task automatic test_flush();
        OutEN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'h300 + 32'(4 * i));
            model_push();
            tick();
        end
        set_in(1'b1, 32'h308);
        Flush = 1'b1;
        OutEN = 1'b1;
        sb.delete();
        tick();
        Flush = 1'b0;
        set_in(1'b0, '0);
        checks++;
        if (Count !== 3'd0 || OutValid !== 1'b0 || InReady !== 1'b1 || OutPC !== 32'h0) begin
            failures++;
            $display("FAIL flush: got count=%0d valid=%b ready=%b pc=%h expected 0 0 1 0",
                     Count, OutValid, InReady, OutPC);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (OutValid !== 1'b0 || OutPC === 32'h308) begin
                failures++;
                $display("FAIL flush_discard_%0d: got valid=%b pc=%h expected 0 0", i,
                         OutValid, OutPC);
            end
        end
        OutEN = 1'b0;
        set_in(1'b1, 32'h400);
        model_push();
        tick();
        set_in(1'b0, '0);
        test_drain(1);
    endtask

    task automatic test_async_reset();
        OutEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h500 + 32'(4 * i));
            model_push();
            tick();
        end
        set_in(1'b1, 32'h50C);
        #2;
        Reset = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (OutValid !== 1'b0 || Count !== 3'd0 || OutPC !== 32'h0 || OutInstr !== NOP) begin
            failures++;
            $display("FAIL async_reset: got valid=%b count=%0d pc=%h instr=%h expected 0 0 0 %h",
                     OutValid, Count, OutPC, OutInstr, NOP);
        end
        set_in(1'b0, '0);
        tick();
        Reset = 1'b1;
        set_in(1'b1, 32'h600);
        model_push();
        tick();
        set_in(1'b0, '0);
        checks++;
        if (Count !== 3'd1) begin
            failures++;
            $display("FAIL async_reset_recover: got count=%0d expected 1", Count);
        end
        test_drain(1);
    endtask

    initial begin
        test_reset();
        test_fill(32'h0);
        test_overfill();
        test_drain(4);
        test_empty();
        test_stream();
        test_full_pop();
        test_flush();
        test_async_reset();
        test_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
